// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the sequential adder family: default
//               operand width, FSM state encodings and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Default operand width shared by the sequential adder blocks
    localparam int c_DEFAULT_WIDTH = 8;

    // FSM state encodings, fixed so that other blocks can decode them
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RUN  = c_ST_RUN,
        DONE = c_ST_DONE
    } state_t;

    // Bit-counter width for a given operand width; never narrower than 1 bit
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full-adder cell (a + b + cin -> sum, cout).
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder. Computes A + B + cin one bit per clock,
//               LSB first, through a single full-adder cell. Result and
//               carry-out are registered when the last bit is produced and
//               held until the next result.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int            CW         = cnt_width(WIDTH);
    localparam logic [CW-1:0] c_LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Holds the WIDTH-1 sum bits already produced; the final bit arrives
    // straight from the adder on the edge that enters DONE.
    logic [WIDTH-2:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_cout_out;

    logic             w_sum_bit;
    logic             w_carry_bit;
    logic [WIDTH-1:0] w_sum_next;

    // The only arithmetic in the block: one bit per RUN cycle
    full_adder u_full_adder (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_sum_bit),
        .cout (w_carry_bit)
    );

    // Sum register contents after shifting in the current adder output
    assign w_sum_next = {w_sum_bit, r_sum_sr};

    // FSM and datapath: operand capture, serial shift and result latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sum_sr   <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum_out  <= '0;
            r_cout_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_carry  <= cin;
                        r_sum_sr <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_sum_sr <= w_sum_next[WIDTH-1:1];
                    r_carry  <= w_carry_bit;
                    if (r_cnt == c_LAST_BIT) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_sum_out  <= w_sum_next;
                        r_cout_out <= w_carry_bit;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum_out  = r_sum_out;
    assign cout_out = r_cout_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH:0] sb[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH:0]   exp;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse pops one expected result
    always @(negedge clk) begin : g_monitor
        logic [WIDTH:0] e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no pending result",
                         {cout_out, sum_out});
            end else begin
                e = sb.pop_front();
                chk("result", 32'({cout_out, sum_out}), 32'(e));
            end
        end
    end

    // Issue one addition once the adder is not running; expected value queued
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
        int k;
        @(negedge clk);
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        a_in  = a;
        b_in  = b;
        cin   = ci;
        start = 1'b1;
        sb.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Bounded wait for the done pulse
    task automatic wait_done(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    // Count done pulses over a window of cycles
    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin : g_watchdog
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : g_main
        int cnt;
        int t;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 9'h000};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 9'h001};
        vecs[4] = '{8'hAA, 8'h55, 1'b1, 9'h100};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 9'h080};
        vecs[6] = '{8'hA5, 8'h3C, 1'b0, 9'h0E1};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 9'h100};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;

        // Reset state
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum_out), 32'd0);
        chk("reset_cout", 32'(cout_out), 32'd0);

        // First start right after reset release, with latency profile
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        a_in  = 8'h0F;
        b_in  = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        sb.push_back(9'h010);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            chk($sformatf("lat_busy_c%0d", i), 32'(busy), 32'd1);
            chk($sformatf("lat_done_c%0d", i), 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("lat_done_pulse", 32'(done), 32'd1);
        chk("lat_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);

        // Table-driven vectors; expected column checked directly as well
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].ci);
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_sum", i), 32'({cout_out, sum_out}), 32'(vecs[i].exp));
        end

        // start during RUN is ignored
        launch(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignored_start");
        chk("ignored_start_sum", 32'({cout_out, sum_out}), 32'h046);
        count_dones(12, cnt);
        chk("ignored_start_extra_done", 32'(cnt), 32'd0);

        // Asynchronous reset in the middle of RUN
        launch(8'h55, 8'h22, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum_out), 32'd0);
        chk("abort_cout", 32'(cout_out), 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_dones(12, cnt);
        chk("abort_no_done", 32'(cnt), 32'd0);
        launch(8'h03, 8'h04, 1'b0);
        wait_done("after_abort");
        chk("after_abort_sum", 32'({cout_out, sum_out}), 32'h007);

        // start held high across DONE: back-to-back additions
        @(negedge clk);
        @(negedge clk);
        a_in  = 8'h0F;
        b_in  = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        sb.push_back(9'h010);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("b2b_first_done", 32'(done), 32'd1);
        a_in = 8'h80;
        b_in = 8'h80;
        cin  = 1'b1;
        sb.push_back(9'h101);
        @(negedge clk);
        chk("b2b_no_idle_gap", 32'(busy), 32'd1);
        t = 1;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        chk("b2b_done_period", 32'(t), 32'd9);
        @(negedge clk);
        chk("b2b_stop_busy", 32'(busy), 32'd0);
        chk("b2b_stop_done", 32'(done), 32'd0);
        chk("b2b_sum_held", 32'({cout_out, sum_out}), 32'h101);

        // Random operand sets against A + B + cin
        for (int i = 0; i < 1000; i++) begin
            launch(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            wait_done("rand");
        end

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port: a_in  input  WIDTH  operand A; captured on the accepted start.
REQ-006 Port: b_in  input  WIDTH  operand B; captured on the accepted start.
REQ-007 Port: cin  input  1  carry-in; captured on the accepted start.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 Port: sum_out  output  WIDTH  registered sum.
REQ-011 Port: cout_out  output  1  registered final carry-out.

Function
REQ-012 Adds A+B+cin bit-serially, LSB first, one bit per clock, through a single 1-bit full-adder cell.
REQ-013 FSM states: IDLE, RUN, DONE.
- IDLE --start--> RUN.
- RUN --bit counter reaches WIDTH-1--> DONE.
- DONE --start--> RUN; DONE --no start--> IDLE.
REQ-014 Accepted start: start=1 while in IDLE or DONE. On that edge, A and B load into shift registers, cin loads into the carry register, and the bit counter clears to 0.
REQ-015 start while in RUN is ignored; captured operands are unaffected.
REQ-016 Each RUN cycle:
- full adder takes A[0], B[0] and the carry register;
- sum bit shifts into the MSB of the sum shift register;
- A and B shift right by one;
- carry register takes the adder carry;
- counter increments.
REQ-017 Latency: start accepted at edge k gives done=1 during the cycle after edge k+WIDTH, exactly WIDTH cycles in RUN.
REQ-018 busy=1 exactly when state=RUN; done=1 exactly when state=DONE.
REQ-019 sum_out and cout_out update only on the edge that enters DONE. They hold that value until the next entry into DONE, including through IDLE and a following RUN.
REQ-020 Arithmetic: {cout_out, sum_out} = A + B + cin, modulo 2^(WIDTH+1); no overflow flag.
REQ-021 Counter width is clog2(WIDTH); it does not wrap inside RUN.

Reset
REQ-022 rst=1 immediately forces, regardless of clk:
- state=IDLE;
- busy=0, done=0;
- sum_out=0, cout_out=0;
- counter, carry and shift registers = 0.
REQ-023 Reset during RUN aborts the addition; no done pulse is produced for it.
REQ-024 First start is honoured on the first rising edge after rst deasserts.

Structure
REQ-025 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default live in the shared adder package/header, reused by other sequential adder blocks.
REQ-026 One sub-module: the team's existing full_adder cell, instantiated once for the per-bit add; no other arithmetic.
REQ-027 Datapath registers and FSM sit in a single clocked process with the async reset in its sensitivity list.

Verification (WIDTH=8)
REQ-028 A=0x0F, B=0x01, cin=0, start at edge 0:
- busy high for edges 1..8;
- done high after edge 8;
- sum_out=0x10, cout_out=0.
REQ-029 A=0xFF, B=0x01, cin=0: sum_out=0x00, cout_out=1.
REQ-030 A=0xFF, B=0xFF, cin=1: sum_out=0xFF, cout_out=1.
REQ-031 Start with A=0x12, B=0x34; at cycle 3 pulse start with A=0xFF, B=0xFF: second start ignored; result 0x46, cout 0.
REQ-032 Assert rst at cycle 4 of RUN: busy=0 and sum_out=0 immediately; no done afterwards. A new start computes 0x03+0x04 -> 0x07.
REQ-033 start held high across DONE:
- second addition begins on the DONE edge with no IDLE cycle;
- done pulses every 9 cycles.
Also add a random self-check of 1000 operand sets against A+B+cin.
